pipe_stall_ctrl: RTL and testbench

Central hazard and stall sequencer for the 5-stage pipeline. It drives the hold (freeze) and flush controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers; memwb_hold connects directly to MEM_WB's waiting input.
- Merges three event sources: memory wait from the IM/DM bus masters, load-use hazards, and branch/jump redirects.
- Applies a programmable settle window after memory wait releases.
- Remembers redirects that arrive during a stall.
- Keeps saturating performance counters.

---
 rtl/pipe_stall_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: merges memory wait,
// load-use bubbles and redirects into per-register hold/flush controls.
module pipe_stall_ctrl #(
    parameter int RESUME_CYC = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             im_wait,
    input  logic             dm_req,
    input  logic             dm_wait,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             memwb_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // state    | meaning
    // ST_RUN   | pipeline free-running; redirect / load-use resolved here
    // ST_WAIT  | memory wait outstanding, everything frozen
    // ST_SETTLE| wait released, holding until the settle window expires
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam int SET_W = (RESUME_CYC > 2) ? $clog2(RESUME_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'((RESUME_CYC > 0) ? RESUME_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nxt;
    logic [SET_W-1:0] settle_cnt, settle_cnt_nxt;
    logic             flush_pend;

    logic wait_any, lu, redirect;
    logic hold_all, free_cyc, do_redirect, do_bubble;

    assign wait_any = im_wait | (dm_req & dm_wait);
    assign lu = ex_is_load & (ex_rd != 5'd0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign redirect = ex_branch_taken | flush_pend;

    // The WAIT cycle in which wait_any falls is the first of the RESUME_CYC
    // held cycles, so SETTLE with an expired counter is already a free cycle.
    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        hold_all       = 1'b0;
        free_cyc       = 1'b0;
        case (state)
            ST_RUN: begin
                if (wait_any) begin
                    hold_all  = 1'b1;
                    state_nxt = ST_WAIT;
                end else begin
                    free_cyc = 1'b1;
                end
            end
            ST_WAIT: begin
                if (wait_any) begin
                    hold_all = 1'b1;
                end else if (RESUME_CYC == 0) begin
                    free_cyc  = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    hold_all       = 1'b1;
                    settle_cnt_nxt = SET_LOAD;
                    state_nxt      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (wait_any) begin
                    hold_all       = 1'b1;
                    settle_cnt_nxt = '0;
                    state_nxt      = ST_WAIT;
                end else if (settle_cnt == '0) begin
                    free_cyc  = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    hold_all       = 1'b1;
                    settle_cnt_nxt = settle_cnt - 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
        if (rst) begin
            hold_all = 1'b0;
            free_cyc = 1'b0;
        end
    end

    assign do_redirect = free_cyc & redirect;
    assign do_bubble   = free_cyc & lu & ~redirect;

    assign pc_hold    = hold_all | do_bubble;
    assign ifid_hold  = hold_all | do_bubble;
    assign idex_hold  = hold_all;
    assign exmem_hold = hold_all;
    assign memwb_hold = hold_all;
    assign ifid_flush = do_redirect;
    assign idex_flush = do_redirect | do_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            settle_cnt <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            if (do_redirect)
                flush_pend <= 1'b0;
            else if (hold_all & ex_branch_taken)
                flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (memwb_hold && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (do_bubble && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + 1'b1;
            if (do_redirect && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: three instances (settle 0/1/2) share stimulus;
// expected hold/flush patterns go through a scoreboard queue.
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       im_wait, dm_req, dm_wait;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken;

    logic [6:0]  o0, o1, o2;
    logic [31:0] st0, bu0, fl0, st1, bu1, fl1;
    logic [1:0]  st2, bu2, fl2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        int         inst;
        logic [4:0] h;
        logic [1:0] f;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.RESUME_CYC(0), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .im_wait(im_wait), .dm_req(dm_req), .dm_wait(dm_wait),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .pc_hold(o0[6]), .ifid_hold(o0[5]), .idex_hold(o0[4]), .exmem_hold(o0[3]),
        .memwb_hold(o0[2]), .ifid_flush(o0[1]), .idex_flush(o0[0]),
        .stall_cnt(st0), .bubble_cnt(bu0), .flush_cnt(fl0));

    pipe_stall_ctrl #(.RESUME_CYC(1), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .im_wait(im_wait), .dm_req(dm_req), .dm_wait(dm_wait),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .pc_hold(o1[6]), .ifid_hold(o1[5]), .idex_hold(o1[4]), .exmem_hold(o1[3]),
        .memwb_hold(o1[2]), .ifid_flush(o1[1]), .idex_flush(o1[0]),
        .stall_cnt(st1), .bubble_cnt(bu1), .flush_cnt(fl1));

    pipe_stall_ctrl #(.RESUME_CYC(2), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .im_wait(im_wait), .dm_req(dm_req), .dm_wait(dm_wait),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .pc_hold(o2[6]), .ifid_hold(o2[5]), .idex_hold(o2[4]), .exmem_hold(o2[3]),
        .memwb_hold(o2[2]), .ifid_flush(o2[1]), .idex_flush(o2[0]),
        .stall_cnt(st2), .bubble_cnt(bu2), .flush_cnt(fl2));

    task automatic clr();
        im_wait = 0; dm_req = 0; dm_wait = 0;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_is_load = 0; ex_branch_taken = 0;
    endtask

    // h = {pc, ifid, idex, exmem, memwb}, f = {ifid_flush, idex_flush}
    task automatic cyc(input string tag, input int inst, input logic [4:0] h, input logic [1:0] f);
        exp_t e, got;
        logic [6:0] obs;
        e.tag = tag; e.inst = inst; e.h = h; e.f = f;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        case (got.inst)
            0:       obs = o0;
            1:       obs = o1;
            default: obs = o2;
        endcase
        checks++;
        assert (obs === {got.h, got.f}) else begin
            errors++;
            $error("FAIL %s u%0d: observed=%b expected=%b", got.tag, got.inst, obs, {got.h, got.f});
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        assert (act === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, act, exp_v);
        end
    endtask

    task automatic idle(input int n);
        clr();
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        clr();
        rst = 1;
        @(posedge clk); #1;
        // outputs gated during reset even with live hazards
        im_wait = 1; ex_branch_taken = 1; ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
        cyc("rst_gate", 1, 5'b00000, 2'b00);
        clr();
        cyc("rst_idle", 1, 5'b00000, 2'b00);
        rst = 0;
        chk_cnt("rst_stall", st1, 0);
        chk_cnt("rst_bubble", bu1, 0);
        chk_cnt("rst_flush", fl1, 0);

        // dm wait 3 cycles, settle 1
        dm_req = 1; dm_wait = 1;
        cyc("dm_w1", 1, 5'b11111, 2'b00);
        cyc("dm_w2", 1, 5'b11111, 2'b00);
        cyc("dm_w3", 1, 5'b11111, 2'b00);
        dm_wait = 0;
        cyc("dm_settle", 1, 5'b11111, 2'b00);
        cyc("dm_free", 1, 5'b00000, 2'b00);
        chk_cnt("dm_stall_cnt", st1, 4);
        idle(3);

        // load-use bubbles
        ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        cyc("lu_rs2", 1, 5'b11000, 2'b01);
        chk_cnt("lu_bubble1", bu1, 1);
        ex_rd = 0; id_rs2 = 0;
        cyc("lu_x0", 1, 5'b00000, 2'b00);
        chk_cnt("lu_x0_cnt", bu1, 1);
        clr(); ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
        cyc("lu_rs1", 1, 5'b11000, 2'b01);
        id_use_rs1 = 0;
        cyc("lu_nouse", 1, 5'b00000, 2'b00);
        clr(); ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
        cyc("lu_noload", 1, 5'b00000, 2'b00);
        chk_cnt("lu_bubble2", bu1, 2);
        clr();

        // redirect pulse during im_wait, settle 0
        im_wait = 1;
        cyc("br_w1", 0, 5'b11111, 2'b00);
        ex_branch_taken = 1;
        cyc("br_w2", 0, 5'b11111, 2'b00);
        ex_branch_taken = 0;
        cyc("br_w3", 0, 5'b11111, 2'b00);
        im_wait = 0;
        cyc("br_release", 0, 5'b00000, 2'b11);
        cyc("br_after", 0, 5'b00000, 2'b00);
        chk_cnt("br_flush_cnt", fl0, 1);
        idle(4);

        // redirect beats load-use in the same cycle
        ex_branch_taken = 1; ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        cyc("br_lu", 1, 5'b00000, 2'b11);
        clr();
        chk_cnt("br_lu_bubble", bu1, 2);
        chk_cnt("br_lu_flush", fl1, 2);
        chk_cnt("stall_total", st1, 8);
        idle(2);

        // settle 2 interrupted by wait re-assertion
        im_wait = 1;
        cyc("s2_a", 2, 5'b11111, 2'b00);
        im_wait = 0;
        cyc("s2_b", 2, 5'b11111, 2'b00);
        im_wait = 1;
        cyc("s2_c", 2, 5'b11111, 2'b00);
        cyc("s2_d", 2, 5'b11111, 2'b00);
        im_wait = 0;
        cyc("s2_e", 2, 5'b11111, 2'b00);
        cyc("s2_f", 2, 5'b11111, 2'b00);
        cyc("s2_g", 2, 5'b00000, 2'b00);
        cyc("s2_h", 2, 5'b00000, 2'b00);
        chk_cnt("sat_stall", {30'd0, st2}, 3);
        idle(3);

        // reset mid-wait with a pending redirect
        im_wait = 1;
        cyc("rw_a", 1, 5'b11111, 2'b00);
        ex_branch_taken = 1;
        cyc("rw_b", 1, 5'b11111, 2'b00);
        ex_branch_taken = 0; rst = 1;
        cyc("rw_rst", 1, 5'b00000, 2'b00);
        rst = 0; clr();
        chk_cnt("rw_stall", st1, 0);
        chk_cnt("rw_bubble", bu1, 0);
        chk_cnt("rw_flush", fl1, 0);
        cyc("rw_post1", 1, 5'b00000, 2'b00);
        cyc("rw_post2", 1, 5'b00000, 2'b00);
        chk_cnt("rw_flush_after", fl1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
